// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths, command record and index-width helper for the SRAM controller
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 4;
    localparam int SRAM_DATA_W = 4;
    localparam int SRAM_NUM_REQ = 2;

    typedef struct packed {
        logic                   wr;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
    } sram_cmd_t;

    function automatic int req_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REQ_IDX_W = req_idx_w(SRAM_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered last-grant pointer
//   clk, reset : clock and synchronous active-high reset
//   req        : N request lines
//   accept     : grant was taken this cycle, advance the pointer
//   grant      : one-hot grant, zero when idle or in reset
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int N = SRAM_NUM_REQ
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int W = req_idx_w(N);

    logic [W-1:0] r_last;
    logic [W-1:0] w_idx;
    logic         w_found;

    // First valid requester found scanning from r_last+1, wrapping.
    always_comb begin
        grant   = '0;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(r_last) + 1 + i) % N;
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_idx   = W'(j);
            end
        end
        if (w_found && !reset) grant[w_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) r_last <= W'(N - 1);
        else if (accept) r_last <= w_idx;
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one single-port SRAM among NUM_REQ requesters
//   req_valid/req_ready/req_wr/req_addr/req_wdata : per-requester command handshake (packed, req 0 in LSBs)
//   rsp_valid/rsp_rdata                           : one-hot read-return strobe and shared read data
//   mem_wr/mem_rd/mem_addr/mem_din/mem_dout       : registered SRAM pins and SRAM read data
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = SRAM_DATA_W,
    parameter int NUM_REQ    = SRAM_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_wr,
    output logic                          mem_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_din,
    input  logic [DATA_WIDTH-1:0]         mem_dout
);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_accept;
    cmd_t                  w_cmd;
    logic                  r_wr;
    logic                  r_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [NUM_REQ-1:0]    r_src;
    logic [NUM_REQ-1:0]    r_tag;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .accept (w_accept),
        .grant  (w_grant)
    );

    assign req_ready = w_grant;
    assign w_accept  = |(req_valid & w_grant);

    always_comb begin
        w_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_cmd.wr   = req_wr[i];
                w_cmd.addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_cmd.data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // r_src remembers who owns the command on the pins; r_tag follows it
    // one edge later, when the SRAM has actually performed the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
            r_src  <= '0;
            r_tag  <= '0;
        end else begin
            r_wr  <= w_accept && w_cmd.wr;
            r_rd  <= w_accept && !w_cmd.wr;
            r_tag <= r_rd ? r_src : '0;
            if (w_accept) begin
                r_addr <= w_cmd.addr;
                r_din  <= w_cmd.wr ? w_cmd.data : '0;
                r_src  <= w_grant;
            end
        end
    end

    assign mem_wr    = r_wr;
    assign mem_rd    = r_rd;
    assign mem_addr  = r_addr;
    assign mem_din   = r_din;
    assign rsp_valid = r_tag;
    assign rsp_rdata = mem_dout;

endmodule
